// File: rtl/dram_if_pkg.sv
// Shared definitions for the FTL DRAM client interface: default widths,
// command encodings, burst geometry and the grant FSM state type.
package dram_if_pkg;

    localparam int unsigned DFLT_IO_WIDTH       = 256;
    localparam int unsigned DFLT_ADDR_WIDTH     = 29;
    localparam int unsigned DFLT_MASK_WIDTH     = 32;
    localparam int unsigned DFLT_MEM_DEPTH_LOG2 = 10;
    localparam int unsigned DFLT_RD_LATENCY     = 4;
    localparam int unsigned DFLT_INIT_CYCLES    = 16;
    localparam int unsigned DFLT_WDF_DEPTH_LOG2 = 4;

    localparam logic DRAM_CMD_WRITE = 1'b0;
    localparam logic DRAM_CMD_READ  = 1'b1;

    // One burst is two beats and covers eight 64-bit address units.
    localparam int unsigned BURST_BEATS     = 2;
    localparam int unsigned BURST_ADDR_STEP = 8;

    typedef enum logic [0:0] {
        G_IDLE    = 1'b0,
        G_GRANTED = 1'b1
    } grant_state_e;

endpackage

// File: rtl/dram_wdf_fifo.sv
// Write-data FIFO holding {mask, data} beats. Exposes the two oldest entries
// so a write command can consume a whole burst in one cycle.
//   clk, reset     : clock, async active-low reset (pointers/count only)
//   push_i/_data_i : enqueue one entry (caller guarantees not full)
//   pop2_i         : dequeue two entries (caller guarantees count >= 2)
//   head0_c/head1_c: oldest and second-oldest entries
//   count_o        : registered occupancy
//   full_c         : occupancy equals depth
module dram_wdf_fifo #(
    parameter int unsigned WIDTH      = 288,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop2_i,
    output logic [WIDTH-1:0]      head0_c,
    output logic [WIDTH-1:0]      head1_c,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_c
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem_q [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_p1;
    logic [CNT_W-1:0]      count_q, count_d;

    // Pointer and occupancy update; pointers wrap naturally at depth.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_ptr_p1 = rd_ptr_q + DEPTH_LOG2'(1);
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop2_i) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(2);
        end
        count_d = count_q + CNT_W'(push_i) - CNT_W'({pop2_i, 1'b0});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only occupancy defines what is valid.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head0_c = mem_q[rd_ptr_q];
    assign head1_c = mem_q[rd_ptr_p1];
    assign count_o = count_q;
    assign full_c  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/dram_responder.sv
// Behavioural DRAM-side responder for the FTL DRAM client interface.
// Models PHY init, single-owner grant/release, command acceptance, write
// beat buffering, a byte-masked burst store and fixed-latency two-beat reads.
//   clk, reset                : clock, async active-low reset
//   phy_init_done             : sticky init-complete flag
//   dram_request_i/release_*  : ownership request / one-cycle release pulse
//   dram_permit_o             : ownership granted
//   dram_en_i/dram_rd_wr_i    : command valid / 0 write, 1 read
//   addr_to_dram_i            : command address in 64-bit word units
//   dram_ready_o              : command accepted when en & ready (comb)
//   data_to_dram_*            : write beat valid/end/data/mask
//   data_to_dram_ready_o      : beat accepted when en & ready (comb)
//   rd_data_valid_o/data_from_dram_o : read beats
//   proto_err_o               : sticky beat-parity violation flag
module dram_responder
    import dram_if_pkg::*;
#(
    parameter int unsigned DRAM_IO_WIDTH   = DFLT_IO_WIDTH,
    parameter int unsigned DRAM_ADDR_WIDTH = DFLT_ADDR_WIDTH,
    parameter int unsigned DRAM_MASK_WIDTH = DFLT_MASK_WIDTH,
    parameter int unsigned MEM_DEPTH_LOG2  = DFLT_MEM_DEPTH_LOG2,
    parameter int unsigned RD_LATENCY      = DFLT_RD_LATENCY,
    parameter int unsigned INIT_CYCLES     = DFLT_INIT_CYCLES,
    parameter int unsigned WDF_DEPTH_LOG2  = DFLT_WDF_DEPTH_LOG2
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       phy_init_done,
    input  logic                       dram_request_i,
    input  logic                       release_dram_i,
    output logic                       dram_permit_o,
    input  logic                       dram_en_i,
    input  logic                       dram_rd_wr_i,
    input  logic [DRAM_ADDR_WIDTH-1:0] addr_to_dram_i,
    output logic                       dram_ready_o,
    input  logic                       data_to_dram_en_i,
    input  logic                       data_to_dram_end_i,
    input  logic [DRAM_IO_WIDTH-1:0]   data_to_dram_i,
    input  logic [DRAM_MASK_WIDTH-1:0] dram_data_mask_i,
    output logic                       data_to_dram_ready_o,
    output logic                       rd_data_valid_o,
    output logic [DRAM_IO_WIDTH-1:0]   data_from_dram_o,
    output logic                       proto_err_o
);

    localparam int unsigned WDF_W       = DRAM_MASK_WIDTH + DRAM_IO_WIDTH;
    localparam int unsigned CNT_W       = WDF_DEPTH_LOG2 + 1;
    localparam int unsigned MEM_DEPTH   = 2 ** MEM_DEPTH_LOG2;
    localparam int unsigned BURST_LSB   = $clog2(BURST_ADDR_STEP);
    localparam int unsigned IDX_MSB     = MEM_DEPTH_LOG2 + BURST_LSB - 1;
    localparam int unsigned INIT_W      = $clog2(INIT_CYCLES + 1);
    localparam int unsigned PIPE_STAGES = RD_LATENCY - 1;

    // ---------------- control state ----------------
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              init_done_q, init_done_d;
    grant_state_e      gstate_q, gstate_d;
    logic              permit_q, permit_d;
    logic              parity_q, parity_d;
    logic              proto_err_q, proto_err_d;
    logic              rd_acc_q;

    logic              active;
    logic              beat_acc;
    logic              wr_ready, rd_ready;
    logic              cmd_acc, wr_acc, rd_acc;

    // ---------------- write FIFO ----------------
    logic [WDF_W-1:0]  wdf_head0, wdf_head1;
    logic [CNT_W-1:0]  wdf_count;
    logic              wdf_full;

    logic [DRAM_IO_WIDTH-1:0]   beat0_data, beat1_data;
    logic [DRAM_MASK_WIDTH-1:0] beat0_mask, beat1_mask;

    // ---------------- burst store / read path ----------------
    logic [DRAM_IO_WIDTH-1:0]   mem_lo_q [0:MEM_DEPTH-1];
    logic [DRAM_IO_WIDTH-1:0]   mem_hi_q [0:MEM_DEPTH-1];
    logic [MEM_DEPTH_LOG2-1:0]  burst_idx;
    logic                       unused_addr_bits;

    logic                       rd_vld_q [0:PIPE_STAGES-1];
    logic [2*DRAM_IO_WIDTH-1:0] rd_dat_q [0:PIPE_STAGES-1];
    logic                       hi_pend_q;
    logic [DRAM_IO_WIDTH-1:0]   hi_q;
    logic                       rd_valid_q;
    logic [DRAM_IO_WIDTH-1:0]   rd_data_q;

    // Handshakes are same-cycle combinational; no skid buffering.
    assign active               = init_done_q & permit_q;
    assign data_to_dram_ready_o = active & ~wdf_full;
    assign beat_acc             = data_to_dram_en_i & data_to_dram_ready_o;
    assign wr_ready             = active & (wdf_count >= CNT_W'(BURST_BEATS));
    // Reads are spaced so the two output beats never overlap the next burst.
    assign rd_ready             = active & ~rd_acc_q;
    assign dram_ready_o         = (dram_rd_wr_i == DRAM_CMD_READ) ? rd_ready : wr_ready;
    assign cmd_acc              = dram_en_i & dram_ready_o;
    assign wr_acc               = cmd_acc & (dram_rd_wr_i == DRAM_CMD_WRITE);
    assign rd_acc               = cmd_acc & (dram_rd_wr_i == DRAM_CMD_READ);

    // Address bits above the store depth alias; the in-burst offset is ignored.
    assign burst_idx        = addr_to_dram_i[IDX_MSB:BURST_LSB];
    assign unused_addr_bits = ^{addr_to_dram_i[DRAM_ADDR_WIDTH-1:IDX_MSB+1],
                                addr_to_dram_i[BURST_LSB-1:0]};

    // Init counter, grant FSM and beat-parity checker next state.
    always_comb begin
        init_cnt_d  = init_cnt_q;
        init_done_d = init_done_q;
        gstate_d    = gstate_q;
        parity_d    = parity_q ^ beat_acc;
        proto_err_d = proto_err_q;

        if (!init_done_q) begin
            init_cnt_d = init_cnt_q + INIT_W'(1);
            if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                init_done_d = 1'b1;
            end
        end

        unique case (gstate_q)
            G_IDLE:    if (init_done_q && dram_request_i) gstate_d = G_GRANTED;
            G_GRANTED: if (release_dram_i)                gstate_d = G_IDLE;
            default:                                      gstate_d = G_IDLE;
        endcase
        permit_d = (gstate_d == G_GRANTED);

        // Even beats must not carry end, odd beats must.
        if (beat_acc && (data_to_dram_end_i != parity_q)) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
            gstate_q    <= G_IDLE;
            permit_q    <= 1'b0;
            parity_q    <= 1'b0;
            proto_err_q <= 1'b0;
            rd_acc_q    <= 1'b0;
        end else begin
            init_cnt_q  <= init_cnt_d;
            init_done_q <= init_done_d;
            gstate_q    <= gstate_d;
            permit_q    <= permit_d;
            parity_q    <= parity_d;
            proto_err_q <= proto_err_d;
            rd_acc_q    <= rd_acc;
        end
    end

    dram_wdf_fifo #(
        .WIDTH      (WDF_W),
        .DEPTH_LOG2 (WDF_DEPTH_LOG2)
    ) u_wdf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (beat_acc),
        .push_data_i ({dram_data_mask_i, data_to_dram_i}),
        .pop2_i      (wr_acc),
        .head0_c     (wdf_head0),
        .head1_c     (wdf_head1),
        .count_o     (wdf_count),
        .full_c      (wdf_full)
    );

    assign beat0_data = wdf_head0[DRAM_IO_WIDTH-1:0];
    assign beat0_mask = wdf_head0[WDF_W-1:DRAM_IO_WIDTH];
    assign beat1_data = wdf_head1[DRAM_IO_WIDTH-1:0];
    assign beat1_mask = wdf_head1[WDF_W-1:DRAM_IO_WIDTH];

    // Byte-masked burst commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < DRAM_MASK_WIDTH; b++) begin
                if (!beat0_mask[b]) mem_lo_q[burst_idx][8*b +: 8] <= beat0_data[8*b +: 8];
                if (!beat1_mask[b]) mem_hi_q[burst_idx][8*b +: 8] <= beat1_data[8*b +: 8];
            end
        end
    end

    // Read pipeline: the burst is captured in the accept cycle, so a write
    // committed at the previous edge is already visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                rd_vld_q[s] <= 1'b0;
                rd_dat_q[s] <= '0;
            end
            hi_pend_q  <= 1'b0;
            hi_q       <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_vld_q[0] <= rd_acc;
            rd_dat_q[0] <= rd_acc ? {mem_hi_q[burst_idx], mem_lo_q[burst_idx]} : '0;
            for (int s = 1; s < PIPE_STAGES; s++) begin
                rd_vld_q[s] <= rd_vld_q[s-1];
                rd_dat_q[s] <= rd_dat_q[s-1];
            end

            // Low half first, high half on the following cycle.
            if (rd_vld_q[PIPE_STAGES-1]) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= rd_dat_q[PIPE_STAGES-1][DRAM_IO_WIDTH-1:0];
                hi_pend_q  <= 1'b1;
                hi_q       <= rd_dat_q[PIPE_STAGES-1][2*DRAM_IO_WIDTH-1:DRAM_IO_WIDTH];
            end else if (hi_pend_q) begin
                rd_valid_q <= 1'b1;
                rd_data_q  <= hi_q;
                hi_pend_q  <= 1'b0;
            end else begin
                rd_valid_q <= 1'b0;
                rd_data_q  <= '0;
            end
        end
    end

    assign phy_init_done    = init_done_q;
    assign dram_permit_o    = permit_q;
    assign rd_data_valid_o  = rd_valid_q;
    assign data_from_dram_o = rd_data_q;
    assign proto_err_o      = proto_err_q;

endmodule

// File: tb/tb_dram_responder.sv
// Directed bench for dram_responder with a read-data scoreboard.
module tb_dram_responder;

    localparam int unsigned IO_W   = 256;
    localparam int unsigned ADDR_W = 29;
    localparam int unsigned MASK_W = 32;
    localparam int          RD_LAT = 4;
    localparam int          BOUND  = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              phy_init_done;
    logic              dram_request_i = 1'b0;
    logic              release_dram_i = 1'b0;
    logic              dram_permit_o;
    logic              dram_en_i = 1'b0;
    logic              dram_rd_wr_i = 1'b0;
    logic [ADDR_W-1:0] addr_to_dram_i = '0;
    logic              dram_ready_o;
    logic              data_to_dram_en_i = 1'b0;
    logic              data_to_dram_end_i = 1'b0;
    logic [IO_W-1:0]   data_to_dram_i = '0;
    logic [MASK_W-1:0] dram_data_mask_i = '0;
    logic              data_to_dram_ready_o;
    logic              rd_data_valid_o;
    logic [IO_W-1:0]   data_from_dram_o;
    logic              proto_err_o;

    dram_responder dut (
        .clk                  (clk),
        .reset                (reset),
        .phy_init_done        (phy_init_done),
        .dram_request_i       (dram_request_i),
        .release_dram_i       (release_dram_i),
        .dram_permit_o        (dram_permit_o),
        .dram_en_i            (dram_en_i),
        .dram_rd_wr_i         (dram_rd_wr_i),
        .addr_to_dram_i       (addr_to_dram_i),
        .dram_ready_o         (dram_ready_o),
        .data_to_dram_en_i    (data_to_dram_en_i),
        .data_to_dram_end_i   (data_to_dram_end_i),
        .data_to_dram_i       (data_to_dram_i),
        .dram_data_mask_i     (dram_data_mask_i),
        .data_to_dram_ready_o (data_to_dram_ready_o),
        .rd_data_valid_o      (rd_data_valid_o),
        .data_from_dram_o     (data_from_dram_o),
        .proto_err_o          (proto_err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [IO_W-1:0] data; int due; } exp_t;
    typedef struct { logic [IO_W-1:0] data; logic [MASK_W-1:0] mask; } beat_t;

    exp_t            sb_q[$];
    beat_t           beat_q[$];
    logic [IO_W-1:0] m_lo [int];
    logic [IO_W-1:0] m_hi [int];

    task automatic check(input string tag, input logic [IO_W-1:0] obs, input logic [IO_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int burst_of(input logic [ADDR_W-1:0] a);
        return int'((a >> 3) % 29'd1024);
    endfunction

    function automatic logic [IO_W-1:0] merge(input logic [IO_W-1:0] old_v,
                                              input logic [IO_W-1:0] d,
                                              input logic [MASK_W-1:0] m);
        logic [IO_W-1:0] r;
        r = old_v;
        for (int b = 0; b < 32; b++) begin
            if (!m[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Scoreboard: every valid read beat must match the oldest expectation,
    // both in value and in arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rd_data_valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("rd_unexpected_valid", IO_W'(rd_data_valid_o), IO_W'(1'b0));
            end else begin
                e = sb_q.pop_front();
                check("rd_data", data_from_dram_o, e.data);
                check("rd_cycle", IO_W'(cyc), IO_W'(e.due));
            end
        end
    end

    task automatic send_beat(input logic [IO_W-1:0] d, input logic [MASK_W-1:0] m, input logic e);
        int waits;
        beat_t bt;
        waits              = 0;
        data_to_dram_en_i  = 1'b1;
        data_to_dram_i     = d;
        dram_data_mask_i   = m;
        data_to_dram_end_i = e;
        #1;
        while (data_to_dram_ready_o !== 1'b1 && waits < BOUND) begin
            @(negedge clk);
            #1;
            waits++;
        end
        if (data_to_dram_ready_o !== 1'b1) begin
            check("beat_accept_timeout", IO_W'(data_to_dram_ready_o), IO_W'(1'b1));
        end else begin
            bt.data = d;
            bt.mask = m;
            beat_q.push_back(bt);
        end
        @(negedge clk);
        data_to_dram_en_i  = 1'b0;
        data_to_dram_end_i = 1'b0;
    endtask

    task automatic send_cmd(input logic rd, input logic [ADDR_W-1:0] a, output int waits);
        exp_t  ex;
        beat_t b0, b1;
        int    k;
        waits          = 0;
        dram_en_i      = 1'b1;
        dram_rd_wr_i   = rd;
        addr_to_dram_i = a;
        #1;
        while (dram_ready_o !== 1'b1 && waits < BOUND) begin
            @(negedge clk);
            #1;
            waits++;
        end
        k = burst_of(a);
        if (dram_ready_o !== 1'b1) begin
            check("cmd_accept_timeout", IO_W'(dram_ready_o), IO_W'(1'b1));
        end else if (rd) begin
            ex.data = m_lo.exists(k) ? m_lo[k] : 'x;
            ex.due  = cyc + RD_LAT;
            sb_q.push_back(ex);
            ex.data = m_hi.exists(k) ? m_hi[k] : 'x;
            ex.due  = cyc + RD_LAT + 1;
            sb_q.push_back(ex);
        end else if (beat_q.size() >= 2) begin
            b0 = beat_q.pop_front();
            b1 = beat_q.pop_front();
            m_lo[k] = merge(m_lo.exists(k) ? m_lo[k] : 'x, b0.data, b0.mask);
            m_hi[k] = merge(m_hi.exists(k) ? m_hi[k] : 'x, b1.data, b1.mask);
        end
        @(negedge clk);
        dram_en_i = 1'b0;
    endtask

    initial begin
        int w;
        logic [IO_W-1:0] pat;

        // Reset: outputs quiet even with a request pending.
        dram_request_i = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_init_done",  IO_W'(phy_init_done),        '0);
        check("rst_permit",     IO_W'(dram_permit_o),        '0);
        check("rst_cmd_ready",  IO_W'(dram_ready_o),         '0);
        check("rst_beat_ready", IO_W'(data_to_dram_ready_o), '0);
        check("rst_rd_valid",   IO_W'(rd_data_valid_o),      '0);
        check("rst_rd_data",    data_from_dram_o,            '0);
        check("rst_proto_err",  IO_W'(proto_err_o),          '0);

        // Init after 16 edges, permit one edge later.
        reset = 1'b1;
        repeat (15) @(negedge clk);
        check("init_not_yet", IO_W'(phy_init_done), '0);
        @(negedge clk);
        check("init_done", IO_W'(phy_init_done), IO_W'(1'b1));
        check("permit_not_yet", IO_W'(dram_permit_o), '0);
        @(negedge clk);
        check("permit_granted", IO_W'(dram_permit_o), IO_W'(1'b1));

        // Basic write/readback at 0x0.
        pat = {8{32'h7fffffff}};
        send_beat(pat, '0, 1'b0);
        send_beat(pat, '0, 1'b1);
        send_cmd(1'b0, 29'h0, w);
        check("wr0_wait", IO_W'(w), '0);
        send_cmd(1'b1, 29'h0, w);
        check("rd0_wait", IO_W'(w), '0);

        // Six beats queued ahead of three write commands.
        for (int i = 0; i < 6; i++) begin
            send_beat({8{32'(i + 1) * 32'h01010101}}, '0, (i % 2) == 1);
        end
        send_cmd(1'b0, 29'h8, w);
        check("wr8_wait", IO_W'(w), '0);
        send_cmd(1'b0, 29'h10, w);
        check("wr10_wait", IO_W'(w), '0);
        send_cmd(1'b0, 29'h18, w);
        check("wr18_wait", IO_W'(w), '0);
        send_cmd(1'b1, 29'h10, w);

        // Byte mask: only byte 0 of each beat is written over zeros.
        send_beat('0, '0, 1'b0);
        send_beat('0, '0, 1'b1);
        send_cmd(1'b0, 29'h20, w);
        send_beat({32{8'hA5}}, 32'hFFFFFFFE, 1'b0);
        send_beat({32{8'h5A}}, 32'hFFFFFFFE, 1'b1);
        send_cmd(1'b0, 29'h20, w);
        send_cmd(1'b1, 29'h20, w);
        @(negedge clk);

        // Back-to-back reads: the second is held one cycle.
        send_cmd(1'b1, 29'h0, w);
        check("rd_b2b_first_wait", IO_W'(w), '0);
        send_cmd(1'b1, 29'h8, w);
        check("rd_b2b_second_wait", IO_W'(w), IO_W'(1));

        // Read in the cycle right after a write sees the new data.
        send_beat({8{32'hC0FFEE01}}, '0, 1'b0);
        send_beat({8{32'hBEEF0002}}, '0, 1'b1);
        send_cmd(1'b0, 29'h28, w);
        send_cmd(1'b1, 29'h28, w);
        check("rd_after_wr_wait", IO_W'(w), '0);

        // Parity violation: end on an even beat.
        check("proto_clean", IO_W'(proto_err_o), '0);
        send_beat({8{32'hDEADBEEF}}, '0, 1'b1);
        check("proto_set", IO_W'(proto_err_o), IO_W'(1'b1));
        repeat (3) @(negedge clk);
        check("proto_sticky", IO_W'(proto_err_o), IO_W'(1'b1));

        // Release with a read in flight.
        send_cmd(1'b1, 29'h18, w);
        release_dram_i = 1'b1;
        dram_request_i = 1'b0;
        @(negedge clk);
        release_dram_i = 1'b0;
        check("release_permit", IO_W'(dram_permit_o), '0);
        dram_en_i    = 1'b1;
        dram_rd_wr_i = 1'b1;
        #1;
        check("idle_cmd_ready",  IO_W'(dram_ready_o),         '0);
        check("idle_beat_ready", IO_W'(data_to_dram_ready_o), '0);
        @(negedge clk);
        dram_en_i = 1'b0;

        for (int i = 0; i < BOUND && sb_q.size() > 0; i++) @(negedge clk);
        check("scoreboard_drain", IO_W'(sb_q.size()), '0);
        check("proto_final", IO_W'(proto_err_o), IO_W'(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_responder.md
# dram_responder

Behavioural DRAM-side responder for the FTL DRAM client interface. It models PHY init completion, single-owner grant/release arbitration, command acceptance, and write-data buffering. Writes land in a parameterised burst store; reads return two-beat bursts after a fixed latency. It is the far end of the interface driven by the FTL init/table engines, and is used as the memory model in FTL block and system benches and in small FPGA bring-up builds without MIG.

## Interface
- DRAM_IO_WIDTH, 256: data beat width (bits).
- DRAM_ADDR_WIDTH, 29: address width; unit is one 64-bit word.
- DRAM_MASK_WIDTH, 32: byte mask width; 1 = byte not written.
- MEM_DEPTH_LOG2, 10: log2 of stored 512-bit bursts.
- RD_LATENCY, 4: cycles from read accept to first rd_data_valid_o (≥2).
- INIT_CYCLES, 16: cycles after reset release before phy_init_done rises.
- WDF_DEPTH_LOG2, 4: write-data FIFO depth (log2 beats).
- clk  in  1  sole clock; rising edge.
- reset  in  1  asynchronous, active-low.
- phy_init_done  out  1  init complete; sticky until reset.
- dram_request_i  in  1  client requests ownership.
- release_dram_i  in  1  one-cycle pulse; client releases ownership.
- dram_permit_o  out  1  ownership granted.
- dram_en_i  in  1  command valid; held until accepted.
- dram_rd_wr_i  in  1  0 = write, 1 = read.
- addr_to_dram_i  in  DRAM_ADDR_WIDTH  command address.
- dram_ready_o  out  1  command accepted when dram_en_i & dram_ready_o.
- data_to_dram_en_i  in  1  write beat valid.
- data_to_dram_end_i  in  1  marks the second beat of a burst.
- data_to_dram_i  in  DRAM_IO_WIDTH  write beat data.
- dram_data_mask_i  in  DRAM_MASK_WIDTH  write beat byte mask.
- data_to_dram_ready_o  out  1  beat accepted when en & ready.
- rd_data_valid_o  out  1  read beat valid.
- data_from_dram_o  out  DRAM_IO_WIDTH  read beat data.
- proto_err_o  out  1  sticky protocol-violation flag.

## Operation
- Reset values: all outputs 0. Counters, FIFO, and read pipeline are cleared. Memory contents are not reset.
- Init: a counter runs from reset release; phy_init_done goes to 1 when the count reaches INIT_CYCLES.
- Grant FSM:
  - G_IDLE → G_GRANTED when phy_init_done & dram_request_i; dram_permit_o = 1 from the next cycle.
  - G_GRANTED → G_IDLE on release_dram_i.
  - dram_request_i is ignored while granted. release_dram_i is ignored while idle.
- "active" = phy_init_done & dram_permit_o.
- Write beats: data_to_dram_ready_o = active & FIFO not full. Each accepted beat pushes {data, mask} to the FIFO.
- Beat parity:
  - A parity bit toggles on every accepted beat.
  - proto_err_o sets if end=1 on an even beat or end=0 on an odd beat.
  - Data may precede its command by any number of beats.
- Command ready (combinational on dram_rd_wr_i):
  - Write: active & FIFO count ≥ 2.
  - Read: active & no read accepted in the previous cycle.
- Write accept:
  - Pop two beats.
  - Burst index = addr[MEM_DEPTH_LOG2+2:3]; higher bits alias (wrap); addr[2:0] ignored.
  - Beat0 → bits[255:0], beat1 → bits[511:256].
  - Per-byte merge: a byte is written only where its mask bit = 0.
  - Commit happens in the accept cycle.
- Read accept:
  - Burst is read in the accept cycle and pushed into a RD_LATENCY-deep pipeline.
  - Output: beat0 (low half) then beat1 on consecutive cycles, rd_data_valid_o = 1 on both.
- Ordering: a read accepted after a write accept returns the new data, including a read accepted in the very next cycle.
- Release with work in flight: permit drops. Queued write beats are retained, but their commands cannot be accepted until a re-grant. Pending read beats still return.
- Reset mid-operation: FIFO contents, in-flight reads, grant and init restart. Memory retains its contents.
- dram_en_i asserted while not active: not accepted, no error.

## Timing
- Grant latency: 1 cycle from request sample to dram_permit_o.
- Release latency: 1 cycle to drop.
- Command and beat acceptance are same-cycle combinational handshakes; no skid.
- Read: accept at cycle T → valid at T+RD_LATENCY and T+RD_LATENCY+1.
- Maximum read throughput: one command per 2 cycles, giving continuous valid data.
- Write throughput: one command per cycle while the FIFO holds ≥2 beats; beat ingress is 1 per cycle.

## Structure
- Shared package dram_if_pkg:
  - Width parameters.
  - DRAM_CMD_WRITE = 1'b0, DRAM_CMD_READ = 1'b1.
  - BURST_BEATS = 2, BURST_ADDR_STEP = 8.
  - Grant state enum.
- Sub-module dram_wdf_fifo: synchronous FIFO of {mask, data} with count output and dual-pop capability. Async active-low reset on pointers and count only.
- Burst store: two arrays of 2^MEM_DEPTH_LOG2 × 256 (low and high halves).

## Test plan
- Reset, hold dram_request_i = 1 → phy_init_done rises after 16 cycles and permit one cycle later. All outputs 0 during reset.
- Write addr 0x0, beats 0x7fffffff-pattern/mask 0, end on beat 2; read addr 0x0 → two valid beats equal to the pattern, 4 and 5 cycles after accept.
- Send 6 beats before any command, then write commands at addr 0x8, 0x10, 0x18 → each accepted as soon as offered; readback of 0x10 returns beats 3–4.
- Write addr 0x20 with mask 0xFFFFFFFE on both beats over prior data 0 → readback byte 0 of each beat is the new value, other bytes 0.
- Back-to-back reads at 0x0 and 0x8 → second is held off one cycle; 4 consecutive valid cycles; a read next cycle after a write to 0x28 returns the new data.
- end=1 on the first beat → proto_err_o = 1 and stays set; release_dram_i pulse with a read in flight → permit drops next cycle and read data still returns.
